fc_ctrl: RTL and testbench

Control unit for the P=1 fully-connected layer datapath (y = f(W·x + b), M outputs, N inputs, T-bit data). It owns the input-side handshake, the input-vector memory write/read addresses, the weight-ROM address, the MAC sequencing strobes and the output-register valid/ready handshake. It sits beside the datapath inside the top-level `fc_<M>_<N>_<T>_1_<R>` wrapper. Bias add, ReLU and saturation are handled by the datapath, not by this block.

---
 rtl/fc_ctrl_if.sv | 30 +++
 rtl/fc_ctrl.sv | 112 +++++++++++
 tb/tb_fc_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fc_ctrl_if.sv
// Handshake and memory-address bundle between the FC control unit and its datapath.
// master = control unit, slave = datapath / upstream / downstream side.
interface fc_ctrl_if #(
  parameter int XAW = 3,
  parameter int WAW = 6
);
  logic           input_valid;
  logic           input_ready;
  logic           x_wr_en;
  logic [XAW-1:0] x_wr_addr;
  logic [XAW-1:0] x_rd_addr;
  logic [WAW-1:0] w_rd_addr;
  logic           mac_en;
  logic           mac_first;
  logic           out_load;
  logic           output_valid;
  logic           output_ready;

  modport master (
    input  input_valid, output_ready,
    output input_ready, x_wr_en, x_wr_addr, x_rd_addr, w_rd_addr,
           mac_en, mac_first, out_load, output_valid
  );

  modport slave (
    output input_valid, output_ready,
    input  input_ready, x_wr_en, x_wr_addr, x_rd_addr, w_rd_addr,
           mac_en, mac_first, out_load, output_valid
  );
endinterface

// File: rtl/fc_ctrl.sv
// Sequencer for the P=1 fully-connected layer: loads x, walks W row by row,
// strobes the MAC and hands each row result to the output register.
module fc_ctrl #(
  parameter int M   = 8,
  parameter int N   = 6,
  parameter int XAW = $clog2(N),
  parameter int WAW = $clog2(M*N)
) (
  input  logic       clk,
  input  logic       reset,
  fc_ctrl_if.master  bus
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, LAST, RESULT} state_t;

  state_t         state_q, state_d;
  logic [XAW-1:0] xcnt_q, xcnt_d;
  logic [XAW-1:0] col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           mac_en_q, mac_en_d;
  logic           mac_first_q, mac_first_d;
  logic           ovld_q, ovld_d;
  logic           accept, free, load;

  always_comb begin
    state_d     = state_q;
    xcnt_d      = xcnt_q;
    col_d       = col_q;
    row_d       = row_q;
    accept      = (state_q == LOAD) & ~reset & bus.input_valid;
    free        = ~ovld_q | bus.output_ready;
    load        = (state_q == RESULT) & free & ~reset;
    // MAC strobes trail the address-issue cycle by one to meet the 1-cycle memory read.
    mac_en_d    = (state_q == COMPUTE);
    mac_first_d = (state_q == COMPUTE) & (col_q == '0);

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (xcnt_q == XAW'(N-1)) begin
            xcnt_d  = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = COMPUTE;
          end else begin
            xcnt_d = xcnt_q + XAW'(1);
          end
        end
      end
      COMPUTE: begin
        if (col_q == XAW'(N-1)) begin
          col_d   = '0;
          state_d = LAST;
        end else begin
          col_d = col_q + XAW'(1);
        end
      end
      LAST: state_d = RESULT;
      RESULT: begin
        if (free) begin
          col_d = '0;
          if (row_q == RW'(M-1)) begin
            state_d = LOAD;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // A same-cycle consume and load keeps the register full.
    if (load)
      ovld_d = 1'b1;
    else if (bus.output_ready & ovld_q)
      ovld_d = 1'b0;
    else
      ovld_d = ovld_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      xcnt_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      ovld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xcnt_q      <= xcnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mac_en_q    <= mac_en_d;
      mac_first_q <= mac_first_d;
      ovld_q      <= ovld_d;
    end
  end

  assign bus.input_ready  = (state_q == LOAD) & ~reset;
  assign bus.x_wr_en      = accept;
  assign bus.x_wr_addr    = xcnt_q;
  assign bus.x_rd_addr    = col_q;
  assign bus.w_rd_addr    = WAW'(row_q) * WAW'(N) + WAW'(col_q);
  assign bus.mac_en       = mac_en_q;
  assign bus.mac_first    = mac_first_q;
  assign bus.out_load     = load;
  assign bus.output_valid = ovld_q;
endmodule

// File: tb/tb_fc_ctrl.sv
// Self-checking bench for fc_ctrl: directed phases plus random valid/ready traffic,
// checked every cycle against a row/step reference model of the layer schedule.
module tb_fc_ctrl;
  localparam int M   = 8;
  localparam int N   = 6;
  localparam int XAW = $clog2(N);
  localparam int WAW = $clog2(M*N);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fc_ctrl_if #(.XAW(XAW), .WAW(WAW)) bus ();
  fc_ctrl #(.M(M), .N(N), .XAW(XAW), .WAW(WAW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0, n_err = 0, cyc_n = 0;
  int n_mac = 0, n_first = 0, n_load = 0;
  int last_acc = 0, prev_ld = 0, gap_bad = 0, first_ld = 0;

  // Reference model: loading with m_loaded words, or computing row m_row at step m_step
  // (steps 0..N-1 issue column m_step, step N is the final MAC, step N+1 waits for the output register).
  int m_mode = 0, m_loaded = 0, m_row = 0, m_step = 0;
  bit m_ov = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit iv, input bit ordy, input bit rst);
    bit e_rdy, e_wr, e_ld, fr;
    @(posedge clk); #1;
    bus.input_valid  = iv;
    bus.output_ready = ordy;
    reset            = rst;
    #3;
    cyc_n++;
    e_rdy = !rst && m_mode == 0;
    e_wr  = e_rdy && iv;
    fr    = !m_ov || ordy;
    e_ld  = !rst && m_mode == 1 && m_step == N+1 && fr;
    chk("input_ready", bus.input_ready, e_rdy);
    chk("x_wr_en", bus.x_wr_en, e_wr);
    chk("out_load", bus.out_load, e_ld);
    if (!rst) begin
      chk("output_valid", bus.output_valid, m_ov);
      chk("mac_en", bus.mac_en, m_mode == 1 && m_step >= 1 && m_step <= N);
      chk("mac_first", bus.mac_first, m_mode == 1 && m_step == 1);
      if (e_wr) chk("x_wr_addr", bus.x_wr_addr, m_loaded);
      if (m_mode == 1 && m_step < N) begin
        chk("x_rd_addr", bus.x_rd_addr, m_step);
        chk("w_rd_addr", bus.w_rd_addr, m_row*N + m_step);
      end
    end
    if (bus.mac_en)    n_mac++;
    if (bus.mac_first) n_first++;
    if (bus.out_load) begin
      n_load++;
      if (n_load == 1) first_ld = cyc_n;
      else if (cyc_n - prev_ld != N+2) gap_bad++;
      prev_ld = cyc_n;
    end
    if (rst) begin
      m_mode = 0; m_loaded = 0; m_row = 0; m_step = 0; m_ov = 1'b0;
    end else begin
      if (m_mode == 0) begin
        if (iv) begin
          m_loaded++;
          if (m_loaded == N) begin
            m_loaded = 0; m_mode = 1; m_row = 0; m_step = 0; last_acc = cyc_n;
          end
        end
      end else if (m_step < N+1) begin
        m_step++;
      end else if (fr) begin
        if (m_row == M-1) m_mode = 0;
        else begin m_row++; m_step = 0; end
      end
      if (e_ld) m_ov = 1'b1;
      else if (ordy) m_ov = 1'b0;
    end
  endtask

  initial begin
    int mac_mark;
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b0;

    // Reset with input_valid held high
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    chk("rst_ovld", bus.output_valid, 0);
    chk("rst_mac_en", bus.mac_en, 0);
    chk("rst_mac_first", bus.mac_first, 0);
    chk("rst_out_load", bus.out_load, 0);
    chk("rst_x_wr_en", bus.x_wr_en, 0);
    chk("rst_in_ready", bus.input_ready, 0);

    // Back-to-back vector, no backpressure, input_valid kept high through compute
    n_mac = 0; n_first = 0; n_load = 0; gap_bad = 0;
    for (int i = 0; i < 300 && n_load < M; i++) cyc(1, 1, 0);
    chk("vec_loads", n_load, M);
    chk("vec_macs", n_mac, M*N);
    chk("vec_firsts", n_first, M);
    chk("vec_gap", gap_bad, 0);
    chk("vec_latency", first_ld - last_acc, N+2);
    cyc(1, 1, 0);
    chk("load_resume", bus.input_ready, 1);

    // Backpressure after the first out_load of a vector (loading already started above)
    n_load = 0;
    for (int i = 0; i < 300 && n_load < 1; i++) cyc(1, n_load == 0, 0);
    chk("bp_first", n_load, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    mac_mark = n_mac;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("bp_stall_mac", n_mac, mac_mark);
    chk("bp_stall_ovld", bus.output_valid, 1);
    cyc(0, 1, 0);
    chk("bp_release_load", bus.out_load, 1);
    cyc(0, 1, 0);
    chk("bp_ovld_kept", bus.output_valid, 1);
    for (int i = 0; i < 300 && n_load < M; i++) cyc(0, 1, 0);
    chk("bp_loads", n_load, M);

    // Random valid/ready traffic over 40 vectors
    n_mac = 0; n_first = 0; n_load = 0;
    for (int i = 0; i < 30000 && n_load < 40*M; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0, 0);
    chk("rnd_loads", n_load, 40*M);
    chk("rnd_macs", n_mac, 40*M*N);
    chk("rnd_firsts", n_first, 40*M);

    // Reset during COMPUTE of row 3
    for (int i = 0; i < 500 && !(m_mode == 1 && m_row == 3 && m_step == 2); i++) cyc(1, 1, 0);
    chk("mid_reached_row3", m_row*16 + m_step, 3*16 + 2);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    chk("mid_ovld", bus.output_valid, 0);
    chk("mid_wr_en", bus.x_wr_en, 1);
    chk("mid_wr_addr", bus.x_wr_addr, 0);
    cyc(1, 1, 0);
    chk("mid_wr_addr1", bus.x_wr_addr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
